// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: turns a command handshake into one
// bus cycle, with a watchdog that aborts cycles that never see an ack.
module wb_cmd_master #(
  parameter int          AW       = 16,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_adr,
  input  logic [31:0]   cmd_dat,
  output logic          rsp_valid,
  output logic [31:0]   rsp_dat,
  output logic          rsp_err,
  output logic          busy,
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic          wb_we,
  output logic [AW-1:0] wb_adr,
  output logic [31:0]   wb_dat_o,
  input  logic [31:0]   wb_dat_i,
  input  logic          wb_ack
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e          state_q, state_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [31:0]     rsp_dat_q, rsp_dat_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_dat_d   = rsp_dat_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          we_d    = cmd_we;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // A coincident ack takes priority over the watchdog expiring.
        if (wb_ack) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? dat_q : wb_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cnt_q == CNT_LAST) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = ERR_DATA;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == BUS);
  assign wb_cyc    = cyc_q;
  assign wb_stb    = cyc_q;
  assign wb_we     = we_q;
  assign wb_adr    = adr_q;
  assign wb_dat_o  = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_dat   = rsp_dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed scenarios plus random commands
// against a transaction-level model (latency, response data, error flag).
module tb_wb_cmd_master;

  localparam int          AW   = 16;
  localparam int          TO   = 8;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic          wb_clk = 1'b0;
  logic          wb_rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [31:0]   cmd_dat;
  logic          rsp_valid, rsp_err, busy;
  logic [31:0]   rsp_dat;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_adr;
  logic [31:0]   wb_dat_o, wb_dat_i;
  logic          wb_ack, slave_ack, spur_ack;

  int total = 0;
  int bad   = 0;

  int          ack_delay = 1;   // 0 = slave never acks
  int          stb_cnt;
  logic [31:0] slave_mem [16];
  logic [31:0] model_mem [logic [AW-1:0]];

  always #5 wb_clk = ~wb_clk;
  assign wb_ack = slave_ack | spur_ack;

  wb_cmd_master #(.AW(AW), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err), .busy(busy),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack)
  );

  // Register-file slave: acks ack_delay clocks after it first sees stb.
  always @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      slave_ack <= 1'b0;
      stb_cnt   <= 0;
      wb_dat_i  <= '0;
      for (int i = 0; i < 16; i++) slave_mem[i] <= '0;
    end else if (wb_cyc && wb_stb && !slave_ack) begin
      if (ack_delay != 0 && stb_cnt + 1 == ack_delay) begin
        slave_ack <= 1'b1;
        stb_cnt   <= 0;
        if (wb_we) slave_mem[wb_adr[3:0]] <= wb_dat_o;
        else       wb_dat_i <= slave_mem[wb_adr[3:0]];
      end else begin
        stb_cnt <= stb_cnt + 1;
      end
    end else begin
      slave_ack <= 1'b0;
      if (!wb_cyc) stb_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One command end to end; expectations come from the transaction model.
  task automatic do_cmd(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                        input int delay, input string tag);
    logic [31:0] exp_dat;
    logic        exp_err;
    int          exp_lat, lat, cyc_cnt, guard;
    logic        hold_bad;
    if (delay != 0 && delay + 1 <= TO) begin
      exp_lat = delay + 1;
      exp_err = 1'b0;
      exp_dat = we ? dat : (model_mem.exists(adr) ? model_mem[adr] : 32'h0);
      if (we) model_mem[adr] = dat;
    end else begin
      exp_lat = TO;
      exp_err = 1'b1;
      exp_dat = ERRD;
    end
    ack_delay = delay;
    @(negedge wb_clk);
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge wb_clk);
      guard++;
    end
    check({tag, ".ready"}, {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat;
    @(negedge wb_clk);
    cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = ~adr; cmd_dat = $urandom;
    lat = -1; cyc_cnt = 0; hold_bad = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (rsp_valid) begin
        lat = j;
        break;
      end
      if (wb_cyc && wb_stb) cyc_cnt++;
      if (wb_cyc && (wb_adr !== adr || wb_we !== we || wb_dat_o !== dat || !busy))
        hold_bad = 1'b1;
      @(negedge wb_clk);
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".stb_clocks"}, 32'(cyc_cnt), 32'(exp_lat));
    check({tag, ".hold"}, {31'b0, hold_bad}, 32'd0);
    check({tag, ".err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    check({tag, ".dat"}, rsp_dat, exp_dat);
    @(negedge wb_clk);
    check({tag, ".pulse_end"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, ".ready_back"}, {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] q_adr [3];
    int            pulses [$];
    logic [31:0]   pdat [$];
    logic [31:0]   exp_q [3];
    int            idx, rises, seen;
    logic          acc, prev_cyc;

    wb_rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; spur_ack = 1'b0;
    repeat (3) @(negedge wb_clk);
    check("rst.cyc", {31'b0, wb_cyc}, 32'd0);
    check("rst.stb", {31'b0, wb_stb}, 32'd0);
    check("rst.we", {31'b0, wb_we}, 32'd0);
    check("rst.adr", 32'(wb_adr), 32'd0);
    check("rst.dat_o", wb_dat_o, 32'd0);
    check("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst.rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst.rsp_dat", rsp_dat, 32'd0);
    check("rst.ready", {31'b0, cmd_ready}, 32'd1);
    check("rst.busy", {31'b0, busy}, 32'd0);
    wb_rst = 1'b0;

    do_cmd(1'b1, 16'd1, 32'h12345678, 1, "wr1");
    do_cmd(1'b0, 16'd1, 32'h0, 1, "rd1");
    do_cmd(1'b1, 16'd2, 32'hCAFE0002, 1, "wr2");
    do_cmd(1'b1, 16'd3, 32'hBEEF0003, 2, "wr3");

    // Back-to-back reads with cmd_valid held high throughout.
    q_adr[0] = 16'd1; q_adr[1] = 16'd2; q_adr[2] = 16'd3;
    for (int k = 0; k < 3; k++) exp_q[k] = model_mem[q_adr[k]];
    ack_delay = 1;
    @(negedge wb_clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = q_adr[0];
    idx = 0; rises = 0; prev_cyc = 1'b0;
    for (int t = 0; t < 24; t++) begin
      acc = cmd_ready && cmd_valid;
      @(negedge wb_clk);
      if (rsp_valid) begin
        pulses.push_back(t);
        pdat.push_back(rsp_dat);
      end
      if (wb_cyc && !prev_cyc) rises++;
      prev_cyc = wb_cyc;
      if (acc) begin
        idx++;
        if (idx < 3) cmd_adr = q_adr[idx];
        else         cmd_valid = 1'b0;
      end
    end
    seen = pulses.size();
    check("b2b.pulses", 32'(seen), 32'd3);
    check("b2b.cycles", 32'(rises), 32'd3);
    if (seen == 3) begin
      check("b2b.gap0", 32'(pulses[1] - pulses[0]), 32'd4);
      check("b2b.gap1", 32'(pulses[2] - pulses[1]), 32'd4);
      for (int k = 0; k < 3; k++) check($sformatf("b2b.dat%0d", k), pdat[k], exp_q[k]);
    end

    // Watchdog expiry, then ack landing exactly on the expiry edge, then a late ack.
    do_cmd(1'b1, 16'd5, 32'h55555555, 0, "timeout");
    do_cmd(1'b1, 16'd6, 32'hA5A5A5A5, TO - 1, "edge_wr");
    do_cmd(1'b0, 16'd6, 32'h0, TO - 1, "edge_rd");
    do_cmd(1'b0, 16'd6, 32'h0, TO, "late_ack");

    // Spurious ack while idle.
    @(negedge wb_clk);
    spur_ack = 1'b1;
    @(negedge wb_clk);
    spur_ack = 1'b0;
    check("spur.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("spur.ready", {31'b0, cmd_ready}, 32'd1);
    @(negedge wb_clk);
    check("spur.rsp_valid2", {31'b0, rsp_valid}, 32'd0);
    check("spur.cyc", {31'b0, wb_cyc}, 32'd0);
    do_cmd(1'b0, 16'd2, 32'h0, 1, "after_spur");

    // Random commands against the model.
    for (int n = 0; n < 30; n++)
      do_cmd(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), $urandom,
             int'($urandom_range(0, 7)), $sformatf("rnd%0d", n));

    // Reset asserted one clock after acceptance.
    ack_delay = 3;
    @(negedge wb_clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 16'd1;
    @(posedge wb_clk);
    @(negedge wb_clk);
    cmd_valid = 1'b0;
    @(posedge wb_clk);
    #1 wb_rst = 1'b1;
    #1;
    check("rstmid.cyc", {31'b0, wb_cyc}, 32'd0);
    check("rstmid.stb", {31'b0, wb_stb}, 32'd0);
    @(posedge wb_clk);
    @(negedge wb_clk);
    wb_rst = 1'b0;
    model_mem.delete();
    check("rstmid.ready", {31'b0, cmd_ready}, 32'd1);
    seen = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge wb_clk);
      if (rsp_valid || wb_cyc) seen++;
    end
    check("rstmid.quiet", 32'(seen), 32'd0);
    do_cmd(1'b0, 16'd1, 32'h0, 1, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
